fir_stream_sequencer: RTL and testbench

//  Sequences the 8-bit FIR datapath between 512-bit CCI-P cache lines and the sample stream.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_line_fifo.sv | 61 ++++++
 rtl/fir_stream_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types for the FIR stream sequencer: cache-line geometry and FSM states.
package fir_pkg;
  localparam int LINE_BYTES = 64;
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef logic [LINE_W-1:0] t_line;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_seq_state;
endpackage

// File: rtl/fir_line_fifo.sv
// Synchronous cache-line FIFO. A push on a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise the push is ignored (caller flags it).
module fir_line_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  t_line                        i_data,
  input  logic                         i_pop,
  output t_line                        o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  t_line          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_pop;
  logic           w_do_push;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Line storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/fir_stream_sequencer.sv
// Serializes read-path cache lines byte-by-byte into the FIR, reassembles the
// filtered bytes into lines for the write path, and throttles issue with a byte
// credit counter because the FIR itself cannot be back-pressured.
module fir_stream_sequencer
  import fir_pkg::*;
#(
  parameter int OUT_FIFO_DEPTH = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_lines,
  input  t_line            line_in,
  input  logic             line_in_valid,
  output logic             line_in_ready,
  output logic [7:0]       fir_data_out,
  output logic             fir_valid_out,
  input  logic [7:0]       fir_data_in,
  input  logic             fir_valid_in,
  output t_line            line_out,
  output logic             line_out_valid,
  input  logic             line_out_ready,
  output logic             busy,
  output logic             done,
  output logic             err_overflow
);
  localparam int LIMIT = OUT_FIFO_DEPTH * LINE_BYTES;
  localparam int OW    = $clog2(LIMIT + LINE_BYTES + 1);
  localparam int BW    = $clog2(LINE_BYTES + 1);
  localparam int IW    = $clog2(LINE_BYTES);
  localparam int FCW   = $clog2(OUT_FIFO_DEPTH + 1);

  t_seq_state       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_num_lines, r_lines_in, r_lines_out;
  t_line            r_ser_line;
  logic [BW-1:0]    r_ser_cnt;
  logic [OW-1:0]    r_outstanding;
  logic             r_fir_valid_out;
  logic [7:0]       r_fir_data_out;
  t_line            r_asm_line;
  logic [IW-1:0]    r_asm_idx;
  t_line            r_push_line;
  logic             r_push_vld;
  logic             r_err;

  logic             w_issue, w_ready, w_accept, w_pop, w_job, w_fir_take;
  logic             w_last_byte, w_err_set, w_busy, w_done;
  t_line            w_fifo_head;
  logic             w_fifo_full, w_fifo_empty;
  logic [FCW-1:0]   w_fifo_count;

  // A byte issues only while credit remains for its eventual slot in the output FIFO.
  assign w_issue     = (r_ser_cnt != '0) && (r_outstanding < OW'(LIMIT));
  // The serializer may reload in the same cycle its last byte issues.
  assign w_ready     = (r_state == FEED) && (r_lines_in < r_num_lines) &&
                       ((r_ser_cnt == '0) || ((r_ser_cnt == BW'(1)) && w_issue));
  assign w_accept    = line_in_valid && w_ready;
  assign w_pop       = line_out_ready && !w_fifo_empty;
  assign w_job       = (r_state == FEED) || (r_state == DRAIN);
  assign w_fir_take  = fir_valid_in && w_job;
  assign w_last_byte = (r_asm_idx == IW'(LINE_BYTES - 1));
  assign w_err_set   = (fir_valid_in && !w_job) || (r_push_vld && w_fifo_full && !w_pop);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic plus the state-decoded status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != IDLE);
    w_done      = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = (num_lines == '0) ? DONE : FEED;
      FEED:  if ((r_lines_in == r_num_lines) && (r_ser_cnt == '0)) w_state_nxt = DRAIN;
      DRAIN: if ((r_lines_out == r_num_lines) && (w_fifo_count == '0)) w_state_nxt = DONE;
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job length latch and line counters, cleared when a job starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_lines <= '0;
      r_lines_in  <= '0;
      r_lines_out <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_num_lines <= num_lines;
      r_lines_in  <= '0;
      r_lines_out <= '0;
    end else begin
      if (w_accept) r_lines_in  <= r_lines_in + 1'b1;
      if (w_pop)    r_lines_out <= r_lines_out + 1'b1;
    end
  end

  // Serializer occupancy: a load overrides the shift of the byte issuing alongside it.
  always_ff @(posedge clk) begin
    if (reset)         r_ser_cnt <= '0;
    else if (w_accept) r_ser_cnt <= BW'(LINE_BYTES);
    else if (w_issue)  r_ser_cnt <= r_ser_cnt - 1'b1;
  end

  // Serializer shift register; byte 0 sits in the low bits.
  always_ff @(posedge clk) begin
    if (w_accept)     r_ser_line <= line_in;
    else if (w_issue) r_ser_line <= r_ser_line >> 8;
  end

  // Registered issue port toward the FIR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fir_valid_out <= 1'b0;
      r_fir_data_out  <= '0;
    end else begin
      r_fir_valid_out <= w_issue;
      if (w_issue) r_fir_data_out <= r_ser_line[7:0];
    end
  end

  // Credit counter: bytes issued but not yet popped from the output FIFO.
  always_ff @(posedge clk) begin
    if (reset) r_outstanding <= '0;
    else       r_outstanding <= r_outstanding + OW'(w_issue) - (w_pop ? OW'(LINE_BYTES) : '0);
  end

  // Assembler control: byte index and the one-cycle push request for a completed line.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm_idx  <= '0;
      r_push_vld <= 1'b0;
    end else begin
      r_push_vld <= w_fir_take && w_last_byte;
      if (w_fir_take) r_asm_idx <= w_last_byte ? '0 : r_asm_idx + 1'b1;
    end
  end

  // Assembler data: place each filtered byte, snapshot the line on its last byte.
  always_ff @(posedge clk) begin
    if (w_fir_take) begin
      r_asm_line[8*r_asm_idx +: 8] <= fir_data_in;
      if (w_last_byte) r_push_line <= {fir_data_in, r_asm_line[LINE_W-9:0]};
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  fir_line_fifo #(
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push_vld),
    .i_data  (r_push_line),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign line_in_ready  = w_ready;
  assign fir_data_out   = r_fir_data_out;
  assign fir_valid_out  = r_fir_valid_out;
  assign line_out       = w_fifo_empty ? '0 : w_fifo_head;
  assign line_out_valid = !w_fifo_empty;
  assign busy           = w_busy;
  assign done           = w_done;
  assign err_overflow   = r_err;
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Self-checking bench for fir_stream_sequencer with a 3-cycle passthrough FIR model.
module tb_fir_stream_sequencer;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] num_lines;
  t_line       line_in;
  logic        line_in_valid, line_in_ready;
  logic [7:0]  fir_data_out, fir_data_in;
  logic        fir_valid_out, fir_valid_in;
  t_line       line_out;
  logic        line_out_valid, line_out_ready;
  logic        busy, done, err_overflow;
  logic        inj_v;
  logic [7:0]  inj_d;

  always #5 clk = ~clk;

  fir_stream_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .line_in(line_in), .line_in_valid(line_in_valid), .line_in_ready(line_in_ready),
    .fir_data_out(fir_data_out), .fir_valid_out(fir_valid_out),
    .fir_data_in(fir_data_in), .fir_valid_in(fir_valid_in),
    .line_out(line_out), .line_out_valid(line_out_valid), .line_out_ready(line_out_ready),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  // FIR stand-in: 3-cycle delay passthrough sharing the sequencer reset.
  logic [2:0] pv;
  logic [7:0] pd0, pd1, pd2;
  always @(posedge clk) begin
    if (reset) pv <= '0;
    else       pv <= {pv[1:0], fir_valid_out};
    pd0 <= fir_data_out;
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign fir_valid_in = pv[2] | inj_v;
  assign fir_data_in  = inj_v ? inj_d : pd2;

  // Observers, sampled mid-cycle.
  int         fir_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] byte_q[$];
  t_line      out_q[$];
  always @(negedge clk) begin
    if (fir_valid_out) begin
      fir_cnt++;
      byte_q.push_back(fir_data_out);
    end
    if (line_out_valid && line_out_ready) out_q.push_back(line_out);
    if (done) done_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input t_line act, input t_line exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_fir_valid_out"}, fir_valid_out, 0);
    chk({nm, "_fir_data_out"}, fir_data_out, 0);
    chk({nm, "_line_in_ready"}, line_in_ready, 0);
    chk({nm, "_line_out_valid"}, line_out_valid, 0);
    chk_line({nm, "_line_out"}, line_out, '0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err_overflow, 0);
  endtask

  // mode 0: sink always ready; 1: random line_in/line_out handshakes;
  // 2: sink held off for 600 cycles, then always ready.
  typedef struct {
    int n;
    int mode;
    bit pattern;
    bit restart;
    int exp_bytes;
    int exp_done;
    int exp_lines;
  } job_t;

  task automatic run_job(input job_t j, input int abort);
    t_line jl[9];
    int f0, d0, o0, b0, sent, cyc, bad;
    bit acc;
    for (int i = 0; i < 9; i++) jl[i] = '0;
    for (int i = 0; i < j.n; i++)
      for (int w = 0; w < LINE_BYTES / 4; w++)
        if (j.pattern) begin
          for (int b = 0; b < 4; b++) jl[i][32*w + 8*b +: 8] = 8'(4*w + b);
        end else begin
          jl[i][32*w +: 32] = $urandom();
        end
    f0 = fir_cnt; d0 = done_cnt; o0 = out_q.size(); b0 = byte_q.size();
    @(posedge clk); #1;
    num_lines = j.n; start = 1'b1; line_in_valid = 1'b0;
    line_out_ready = (j.mode == 0);
    sent = 0; cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk);
      acc = line_in_valid && line_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (abort > 0 && (fir_cnt - f0) >= abort) break;
      start = j.restart && (cyc == 30);
      num_lines = start ? 32'd5 : 32'(j.n);
      line_in_valid = (sent < j.n) && (j.mode != 1 || $urandom_range(0, 3) != 0);
      line_in = jl[sent];
      if (j.mode == 2 && cyc == 600) begin
        chk("stall_bytes_at_credit_limit", 64'(fir_cnt - f0), 128);
        chk("stall_fifo_valid", line_out_valid, 1);
      end
      line_out_ready = (j.mode == 0) || (j.mode == 1 && $urandom_range(0, 2) != 0) ||
                       (j.mode == 2 && cyc >= 600);
    end
    start = 1'b0;
    if (abort > 0) begin
      chk("abort_point_reached", 64'((fir_cnt - f0) >= abort), 1);
      return;
    end
    chk("job_finished_in_time", 64'(cyc < 20000), 1);
    line_in_valid = 1'b0; line_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", 64'(done_cnt - d0), 64'(j.exp_done));
    chk("fir_bytes_issued", 64'(fir_cnt - f0), 64'(j.exp_bytes));
    chk("lines_out", 64'(out_q.size() - o0), 64'(j.exp_lines));
    for (int i = 0; i < j.n && (o0 + i) < out_q.size(); i++)
      chk_line("line_out_data", out_q[o0 + i], jl[i]);
    bad = 0;
    for (int i = 0; i < j.n * LINE_BYTES; i++)
      if ((b0 + i) >= byte_q.size() || byte_q[b0 + i] !== jl[i / LINE_BYTES][8*(i % LINE_BYTES) +: 8])
        bad++;
    chk("issue_byte_order", 64'(bad), 0);
    chk("no_overflow", err_overflow, 0);
    chk("idle_after_job", busy, 0);
  endtask

  job_t jobs[4];
  job_t rj;
  int   f0, d0;

  initial begin
    jobs[0] = '{n: 1, mode: 0, pattern: 1'b1, restart: 1'b0, exp_bytes: 64,  exp_done: 1, exp_lines: 1};
    jobs[1] = '{n: 4, mode: 2, pattern: 1'b0, restart: 1'b0, exp_bytes: 256, exp_done: 1, exp_lines: 4};
    jobs[2] = '{n: 2, mode: 0, pattern: 1'b0, restart: 1'b1, exp_bytes: 128, exp_done: 1, exp_lines: 2};
    jobs[3] = '{n: 3, mode: 1, pattern: 1'b0, restart: 1'b0, exp_bytes: 192, exp_done: 1, exp_lines: 3};

    reset = 1'b1; start = 1'b0; num_lines = '0; line_in = '0; line_in_valid = 1'b0;
    line_out_ready = 1'b0; inj_v = 1'b0; inj_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_job(jobs[i], 0);

    // Zero-length job: straight to DONE for a single cycle, nothing issued.
    f0 = fir_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    num_lines = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_job_busy", busy, 1);
    chk("zero_job_done", done, 1);
    @(negedge clk);
    chk("zero_job_busy_after", busy, 0);
    chk("zero_job_done_after", done, 0);
    chk("zero_job_no_issue", 64'(fir_cnt - f0), 0);
    chk("zero_job_done_count", 64'(done_cnt - d0), 1);

    // Reset in the middle of a 3-line job, then a clean job.
    rj = '{n: 3, mode: 0, pattern: 1'b0, restart: 1'b0, exp_bytes: 192, exp_done: 1, exp_lines: 3};
    d0 = done_cnt;
    run_job(rj, 100);
    reset = 1'b1; line_in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midjob_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    chk("midjob_reset_no_done", 64'(done_cnt - d0), 0);
    run_job(jobs[0], 0);

    // Randomized jobs; expectations follow from the job length alone.
    for (int r = 0; r < 3; r++) begin
      rj.n = $urandom_range(1, 6);
      rj.mode = 1; rj.pattern = 1'b0; rj.restart = 1'b0;
      rj.exp_bytes = rj.n * LINE_BYTES; rj.exp_done = 1; rj.exp_lines = rj.n;
      run_job(rj, 0);
    end

    // Stray FIR byte while idle: sticky error, nothing assembled.
    @(posedge clk); #1;
    inj_v = 1'b1; inj_d = 8'hA5;
    @(posedge clk); #1;
    inj_v = 1'b0;
    @(negedge clk);
    chk("inject_err_set", err_overflow, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("inject_err_sticky", err_overflow, 1);
    chk("inject_no_line", line_out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("inject_err_cleared", err_overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
